// File: rtl/pr_ctrl_pkg.sv
// rtl/pr_ctrl_pkg.sv - shared types and encodings for the PR frame sync controller
package pr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    DRAIN,
    DECOUPLED,
    SETTLE,
    RESTORE
  } state_t;

  localparam logic [1:0] MUX_WINDOWED = 2'd0;
  localparam logic [1:0] MUX_FORCE_B  = 2'd1;
  localparam logic [1:0] MUX_FORCE_A  = 2'd2;

  // States in which the missing-video timeout is allowed to advance
  function automatic logic counts_time(state_t s);
    return (s == WAIT_SOF) || (s == DRAIN) || (s == SETTLE) || (s == RESTORE);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - vsync rising-edge detect with a no-video timeout fallback
module frame_tick_gen #(
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int TO_W        = 21
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vsync_in,
  input  logic cnt_en,
  input  logic cnt_clr,
  output logic tick,
  output logic timed_out
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic            vsync_d;
  logic [TO_W-1:0] to_cnt;
  logic            frame_start;
  logic            to_hit;

  assign frame_start = vsync_in & ~vsync_d;
  assign to_hit      = cnt_en & (to_cnt == TO_LAST);
  assign tick        = frame_start | to_hit;
  // A real frame start in the same cycle takes credit for the tick
  assign timed_out   = to_hit & ~frame_start;

  // Delayed vsync; resets high so a vsync already high at release is not an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vsync_d <= 1'b1;
    else          vsync_d <= vsync_in;
  end

  // Timeout counter restarts on every tick so repeated timeouts stay periodic
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        to_cnt <= '0;
    else if (tick || cnt_clr || !cnt_en) to_cnt <= '0;
    else                                 to_cnt <= to_cnt + 1'b1;
  end

endmodule

// File: rtl/pr_frame_sync_ctrl.sv
// rtl/pr_frame_sync_ctrl.sv - frame-synchronous decouple/mux sequencer for PR regions A and B
module pr_frame_sync_ctrl
  import pr_ctrl_pkg::*;
#(
  parameter int SETTLE_FRAMES = 2,
  parameter int TIMEOUT_CYC   = 2_000_000,
  parameter int TO_W          = 21
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vsync_in,
  input  logic       pr_req,
  input  logic       pr_sel,
  input  logic       pr_done,
  output logic       pr_ack,
  output logic       decouple_a,
  output logic       decouple_b,
  output logic [1:0] mux_mode,
  output logic       busy,
  output logic       no_video
);

  state_t     state, state_nx;
  logic       sel, sel_nx;
  logic [3:0] settle_cnt, settle_nx;
  logic [1:0] mux_nx;
  logic       ack_nx, dec_a_nx, dec_b_nx, busy_nx, nv_nx;
  logic       tick, timed_out;

  frame_tick_gen #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .vsync_in (vsync_in),
    .cnt_en   (counts_time(state)),
    .cnt_clr  (state_nx != state),
    .tick     (tick),
    .timed_out(timed_out)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sel        <= 1'b0;
      settle_cnt <= '0;
      mux_mode   <= MUX_WINDOWED;
      pr_ack     <= 1'b0;
      decouple_a <= 1'b0;
      decouple_b <= 1'b0;
      busy       <= 1'b0;
      no_video   <= 1'b0;
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      settle_cnt <= settle_nx;
      mux_mode   <= mux_nx;
      pr_ack     <= ack_nx;
      decouple_a <= dec_a_nx;
      decouple_b <= dec_b_nx;
      busy       <= busy_nx;
      no_video   <= nv_nx;
    end
  end

  // Next state; a dropped request takes priority over a coincident tick
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (pr_req) state_nx = WAIT_SOF;
      WAIT_SOF:  if (!pr_req) state_nx = IDLE;
                 else if (tick) state_nx = DRAIN;
      DRAIN:     if (!pr_req) state_nx = RESTORE;
                 else if (tick) state_nx = DECOUPLED;
      DECOUPLED: if (pr_done) state_nx = SETTLE;
      SETTLE:    if (tick && settle_cnt == 4'd1) state_nx = RESTORE;
      RESTORE:   if (tick) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; the full-frame mux always shows the region not being decoupled
  always_comb begin
    sel_nx    = sel;
    settle_nx = settle_cnt;
    mux_nx    = mux_mode;
    ack_nx    = pr_ack;
    dec_a_nx  = decouple_a;
    dec_b_nx  = decouple_b;
    nv_nx     = no_video | timed_out;
    unique case (state)
      IDLE: if (pr_req) begin
        sel_nx = pr_sel;
        nv_nx  = 1'b0;
      end
      WAIT_SOF: if (pr_req && tick) mux_nx = sel ? MUX_FORCE_A : MUX_FORCE_B;
      DRAIN: if (pr_req && tick) begin
        ack_nx   = 1'b1;
        dec_a_nx = ~sel;
        dec_b_nx = sel;
      end
      DECOUPLED: if (pr_done) begin
        ack_nx    = 1'b0;
        dec_a_nx  = 1'b0;
        dec_b_nx  = 1'b0;
        settle_nx = 4'(SETTLE_FRAMES);
      end
      SETTLE:  if (tick) settle_nx = settle_cnt - 4'd1;
      RESTORE: if (tick) mux_nx = MUX_WINDOWED;
      default: ;
    endcase
    busy_nx = (state_nx != IDLE);
  end

endmodule
